// File: rtl/adc_pkg.sv
// Shared definitions for the SPI ADC scan engine: FSM encoding, default
// parameters and the scan-order helper.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_e;

  localparam int DEF_DATA_BITS  = 14;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_CAL_BITS   = 32;
  localparam int DEF_HALF_DIV   = 8;
  localparam int DEF_CHANNELS   = 8;
  localparam int DEF_CH_BITS    = 3;
  localparam int DEF_ADDR_POS   = 2;

  localparam int MAX_CH   = 64;
  localparam int MAX_CH_W = 6;

  // Next enabled channel strictly above cur, wrapping to the lowest; cur if none.
  function automatic logic [MAX_CH_W-1:0] next_channel(input logic [MAX_CH-1:0]   mask,
                                                        input logic [MAX_CH_W-1:0] cur,
                                                        input int                  nch);
    logic [MAX_CH_W-1:0] res;
    logic                found;
    res   = cur;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (!found && i < nch && i > int'(cur) && mask[i]) begin
        res   = MAX_CH_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < MAX_CH; i++) begin
      if (!found && i < nch && mask[i]) begin
        res   = MAX_CH_W'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_sclk_tick.sv
// SCLK half-period timer: pulses phase_end_o on the last clkin cycle of every
// HALF_DIV-cycle phase; restart_i realigns the phase to start on the next cycle.
module adc_sclk_tick #(
  parameter int HALF_DIV = 8
) (
  input  logic clkin,
  input  logic rst,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam int            CW     = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    phase_end_o = (cnt_q == '0) && !restart_i;
    if (restart_i || cnt_q == '0) cnt_d = RELOAD;
    else                          cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_scan_master.sv
// SPI read engine for an address-in-frame multi-channel ADC: single, scan and
// calibration frames; results leave through a valid/ready register with sticky overrun.
module adc_scan_master
  import adc_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CAL_BITS   = DEF_CAL_BITS,
  parameter int HALF_DIV   = DEF_HALF_DIV,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int CH_BITS    = DEF_CH_BITS,
  parameter int ADDR_POS   = DEF_ADDR_POS
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 calibrate,
  input  logic                 scan,
  input  logic [CH_BITS-1:0]   ch_sel,
  input  logic [CHANNELS-1:0]  ch_mask,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_o,
  output logic [CH_BITS-1:0]   data_ch,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 overrun,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 cs
);

  localparam int                MAXB      = (CAL_BITS > FRAME_BITS) ? CAL_BITS : FRAME_BITS;
  localparam int                CNT_W     = $clog2(MAXB + 1);
  localparam logic [CNT_W-1:0]  LAST_CONV = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_CAL  = CNT_W'(CAL_BITS - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_q, bit_d, last_bit;
  logic [CH_BITS-1:0]   ch_q, ch_d, dch_q, dch_d;
  logic [CHANNELS-1:0]  mask_q, mask_d;
  logic                 cal_q, cal_d, scan_q, scan_d, gap_half_q, gap_half_d;
  logic                 post_q, post_d, shift_en, go_acc, phase_end;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, dout_q, dout_d;
  logic                 dvld_q, dvld_d, ovr_q, ovr_d;
  logic                 busy_q, busy_d, cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [MAX_CH_W-1:0]  first_ch, nxt_ch;

  adc_sclk_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .clkin       (clkin),
    .rst         (rst),
    .restart_i   (go_acc),
    .phase_end_o (phase_end)
  );

  assign first_ch = next_channel(MAX_CH'(ch_mask), MAX_CH_W'(CHANNELS - 1), CHANNELS);
  assign nxt_ch   = next_channel(MAX_CH'(mask_q), MAX_CH_W'(ch_q), CHANNELS);
  assign last_bit = cal_q ? LAST_CAL : LAST_CONV;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    cal_d      = cal_q;
    scan_d     = scan_q;
    gap_half_d = gap_half_q;
    post_d     = 1'b0;
    shift_en   = 1'b0;
    go_acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          go_acc  = 1'b1;
          cal_d   = calibrate;
          scan_d  = scan && !calibrate;
          mask_d  = ch_mask;
          ch_d    = (scan && !calibrate && ch_mask != '0) ? first_ch[CH_BITS-1:0] : ch_sel;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP:    if (phase_end) state_d = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (phase_end) begin
          shift_en = 1'b1;
          if (bit_q == last_bit) begin
            bit_d  = '0;
            post_d = !cal_q;
            // Live scan input decides whether another frame follows.
            if (scan_q && scan) begin
              state_d    = GAP;
              gap_half_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d   = bit_q + CNT_W'(1);
            state_d = SHIFT_LO;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          if (gap_half_q) begin
            gap_half_d = 1'b0;
            state_d    = SETUP;
            if (mask_q != '0) ch_d = nxt_ch[CH_BITS-1:0];
          end else begin
            gap_half_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shift_en ? {shreg_q[DATA_BITS-2:0], miso} : shreg_q;
    busy_d  = (state_d != IDLE);
    cs_d    = (state_d == IDLE) || (state_d == GAP);
    sclk_d  = (state_d == SHIFT_HI);
    mosi_d  = 1'b0;
    if ((state_d == SETUP || state_d == SHIFT_LO || state_d == SHIFT_HI) && !cal_d &&
        int'(bit_d) >= ADDR_POS && int'(bit_d) < ADDR_POS + CH_BITS)
      mosi_d = ch_d[CH_BITS-1-(int'(bit_d)-ADDR_POS)];

    dout_d = dout_q;
    dch_d  = dch_q;
    dvld_d = dvld_q;
    ovr_d  = ovr_q;
    if (dvld_q && data_ready) dvld_d = 1'b0;
    if (go_acc)               ovr_d  = 1'b0;
    if (post_q) begin
      dout_d = shreg_q;
      dch_d  = ch_q;
      dvld_d = 1'b1;
      if (dvld_q && !data_ready) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      ch_q       <= '0;
      mask_q     <= '0;
      cal_q      <= 1'b0;
      scan_q     <= 1'b0;
      gap_half_q <= 1'b0;
      post_q     <= 1'b0;
      shreg_q    <= '0;
      dout_q     <= '0;
      dch_q      <= '0;
      dvld_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      cal_q      <= cal_d;
      scan_q     <= scan_d;
      gap_half_q <= gap_half_d;
      post_q     <= post_d;
      shreg_q    <= shreg_d;
      dout_q     <= dout_d;
      dch_q      <= dch_d;
      dvld_q     <= dvld_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign busy       = busy_q;
  assign data_o     = dout_q;
  assign data_ch    = dch_q;
  assign data_valid = dvld_q;
  assign overrun    = ovr_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs         = cs_q;

endmodule

// File: tb/tb_adc_scan_master.sv
// Bench for adc_scan_master: behavioural ADC on the SPI pins, results checked
// against a queue of expected {channel, value} pairs filled as frames are requested.
module tb_adc_scan_master;

  localparam int HD  = 8;
  localparam int FB  = 16;
  localparam int LAT = 1 + HD * (1 + 2 * FB) + 1;

  typedef struct {
    logic [2:0]  ch;
    logic [13:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, go, calibrate, scan, data_ready;
  logic [2:0]  ch_sel;
  logic [7:0]  ch_mask;
  logic        busy, data_valid, overrun, sclk, mosi, cs;
  logic [13:0] data_o;
  logic [2:0]  data_ch;
  logic        miso = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  int          fidx = 0;
  int          bitp = 0;
  int          fbit = 0;
  int          sclk_rises = 0;
  int          mosi_ones = 0;
  int          vrise = 0;
  logic        vprev = 1'b0;
  logic        in_frame = 1'b0;
  logic [15:0] word = '0;
  logic        mb [0:7];
  logic [2:0]  dec_ch [0:255];

  always #5 clk = ~clk;

  adc_scan_master dut (
    .clkin      (clk),
    .rst        (rst),
    .go         (go),
    .calibrate  (calibrate),
    .scan       (scan),
    .ch_sel     (ch_sel),
    .ch_mask    (ch_mask),
    .busy       (busy),
    .data_o     (data_o),
    .data_ch    (data_ch),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs         (cs)
  );

  function automatic logic [13:0] mkval(input int n);
    logic [31:0] t;
    t = 32'h2A5C + 32'(n) * 32'h0531;
    return t[13:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: a frame returns {2'b00, mkval(frame index)} MSB first, shifting on SCLK falls.
  always @(posedge sclk or negedge sclk or posedge cs or negedge cs) begin
    if (cs !== 1'b0) begin
      if (in_frame) begin
        in_frame = 1'b0;
        if (fidx > 0 && fidx <= 256) dec_ch[fidx-1] = {mb[2], mb[3], mb[4]};
      end
    end else if (!in_frame) begin
      in_frame = 1'b1;
      word     = {2'b00, mkval(fidx)};
      fidx++;
      bitp = 0;
      fbit = 0;
      miso = word[15];
    end else if (sclk) begin
      sclk_rises++;
      mosi_ones += int'(mosi);
      if (fbit < 8) mb[fbit] = mosi;
      fbit++;
    end else begin
      bitp++;
      miso = (bitp < 16) ? word[15-bitp] : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && !vprev) vrise++;
      if (data_valid && data_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_pending", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("data_o", 32'(data_o), 32'(e.val));
          check("data_ch", 32'(data_ch), 32'(e.ch));
        end
      end
    end
    vprev = rst ? 1'b0 : data_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    check(tag, 32'(busy), 0);
  endtask

  task automatic wait_fidx(input int target, input string tag);
    int n = 0;
    while (fidx < target && n < 3000) begin tick(); n++; end
    check(tag, 32'(fidx >= target), 1);
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (sclk_rises < target && n < 3000) begin tick(); n++; end
    check(tag, 32'(sclk_rises >= target), 1);
  endtask

  initial begin
    int   base_r, base_m, vr, idx, cnt;
    int   scan_chs [5] = '{2, 5, 7, 2, 5};
    logic [5:0] mp;

    rst = 1'b1; go = 1'b0; calibrate = 1'b0; scan = 1'b0;
    ch_sel = '0; ch_mask = '0; data_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_cs", 32'(cs), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_ch", 32'(data_ch), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single conversion on channel 5
    base_r = sclk_rises; idx = fidx;
    ch_sel = 3'd5;
    sb_q.push_back('{3'd5, mkval(idx)});
    go = 1'b1;
    tick();
    cnt = 1;
    go = 1'b0;
    while (!data_valid && cnt < 1000) begin tick(); cnt++; end
    check("latency", cnt, LAT);
    mp = {mb[0], mb[1], mb[2], mb[3], mb[4], mb[5]};
    check("mosi_addr", 32'(mp), 32'h0A);
    check("sclk_conv", sclk_rises - base_r, FB);
    check("single_busy", 32'(busy), 0);
    check("single_data", 32'(data_o), 32'h2A5C);
    data_ready = 1'b1;
    repeat (2) tick();
    check("single_drain", sb_q.size(), 0);
    check("single_vclr", 32'(data_valid), 0);

    // Calibration frame
    base_r = sclk_rises; base_m = mosi_ones; vr = vrise;
    calibrate = 1'b1;
    pulse_go();
    calibrate = 1'b0;
    wait_idle("cal_idle");
    repeat (4) tick();
    check("cal_sclk", sclk_rises - base_r, 32);
    check("cal_mosi", mosi_ones - base_m, 0);
    check("cal_novalid", vrise - vr, 0);

    // Continuous scan over mask 1010_0100, dropped during the fifth frame
    idx = fidx;
    for (int k = 0; k < 5; k++) sb_q.push_back('{3'(scan_chs[k]), mkval(idx + k)});
    ch_mask = 8'b1010_0100;
    scan = 1'b1;
    pulse_go();
    wait_fidx(idx + 5, "scan_f5");
    wait_rises(sclk_rises + 5, "scan_mid");
    scan = 1'b0;
    wait_idle("scan_idle");
    repeat (4) tick();
    check("scan_drain", sb_q.size(), 0);
    check("scan_frames", fidx - idx, 5);
    for (int k = 0; k < 5; k++) check("scan_addr", 32'(dec_ch[idx+k]), scan_chs[k]);
    check("scan_ovr", 32'(overrun), 0);

    // Overrun: repeat ch_sel with nobody consuming
    data_ready = 1'b0; ch_mask = '0; ch_sel = 3'd3;
    idx = fidx;
    scan = 1'b1;
    pulse_go();
    wait_fidx(idx + 2, "ovr_f2");
    scan = 1'b0;
    wait_idle("ovr_idle");
    repeat (3) tick();
    check("ovr_set", 32'(overrun), 1);
    check("ovr_valid", 32'(data_valid), 1);
    check("ovr_newest", 32'(data_o), 32'(mkval(idx + 1)));
    check("ovr_ch", 32'(data_ch), 3);
    sb_q.push_back('{3'd3, mkval(idx + 1)});
    data_ready = 1'b1;
    repeat (2) tick();
    check("ovr_drain", sb_q.size(), 0);
    check("ovr_sticky", 32'(overrun), 1);
    idx = fidx; ch_sel = 3'd1;
    sb_q.push_back('{3'd1, mkval(idx)});
    pulse_go();
    check("ovr_goclr", 32'(overrun), 0);
    check("ovr_busy", 32'(busy), 1);
    wait_idle("ovr2_idle");
    repeat (3) tick();
    check("ovr2_drain", sb_q.size(), 0);

    // Ready arrives on the exact cycle a new result posts
    data_ready = 1'b0; idx = fidx; ch_sel = 3'd6;
    sb_q.push_back('{3'd6, mkval(idx)});
    pulse_go();
    cnt = 0;
    while (!data_valid && cnt < 1000) begin tick(); cnt++; end
    check("hs_first", 32'(data_valid), 1);
    ch_sel = 3'd7;
    sb_q.push_back('{3'd7, mkval(idx + 1)});
    pulse_go();
    repeat (LAT - 2) tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("hs_valid", 32'(data_valid), 1);
    check("hs_ovr", 32'(overrun), 0);
    check("hs_data", 32'(data_o), 32'(mkval(idx + 1)));
    check("hs_ch", 32'(data_ch), 7);
    check("hs_popped", sb_q.size(), 1);
    data_ready = 1'b1;
    repeat (2) tick();
    check("hs_drain", sb_q.size(), 0);

    // Reset in the middle of a frame
    ch_sel = 3'd4; base_r = sclk_rises; vr = vrise;
    pulse_go();
    wait_rises(base_r + 7, "rst_7sclk");
    repeat (HD + 2) tick();
    check("rst_midframe", 32'(cs), 0);
    #3 rst = 1'b1;
    #1;
    check("rstm_cs", 32'(cs), 1);
    check("rstm_sclk", 32'(sclk), 0);
    check("rstm_busy", 32'(busy), 0);
    check("rstm_mosi", 32'(mosi), 0);
    check("rstm_valid", 32'(data_valid), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rstm_nopost", vrise - vr, 0);
    check("rstm_valid2", 32'(data_valid), 0);
    idx = fidx; ch_sel = 3'd2;
    sb_q.push_back('{3'd2, mkval(idx)});
    pulse_go();
    wait_idle("rstm_idle");
    repeat (3) tick();
    check("rstm_drain", sb_q.size(), 0);
    check("rstm_addr", 32'(dec_ch[idx]), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
